// File: rtl/pipe_mux_pkg.sv
// Shared sizing helpers and the stage control record for the pipelined N:1 mux.
package pipe_mux_pkg;

    // Flags that travel with every beat; data and sel widths differ per stage.
    typedef struct packed {
        logic valid;
        logic err;
    } stg_ctl_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned calc_d(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int unsigned calc_sw(input int unsigned n);
        return calc_d(n);
    endfunction

    function automatic int unsigned calc_l(input int unsigned n, input int unsigned lps);
        return (calc_d(n) + lps - 1) / lps;
    endfunction

    // Select bits still unresolved when a beat enters stage s.
    function automatic int unsigned stg_sel_in(input int unsigned n, input int unsigned lps,
                                               input int unsigned s);
        return calc_d(n) - s * lps;
    endfunction

    function automatic int unsigned stg_lvls(input int unsigned n, input int unsigned lps,
                                             input int unsigned s);
        int unsigned rem;
        rem = stg_sel_in(n, lps, s);
        return (rem < lps) ? rem : lps;
    endfunction

endpackage

// File: rtl/pipe_mux_stg.sv
// One pipeline stage: LVLS combinational 2:1 levels feeding an enable-gated register.
module pipe_mux_stg
    import pipe_mux_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned SI   = 2,
    parameter int unsigned LVLS = 2,
    localparam int unsigned IN_CH  = 1 << SI,
    localparam int unsigned SO     = SI - LVLS,
    localparam int unsigned SOW    = (SO > 0) ? SO : 1,
    localparam int unsigned OUT_CH = 1 << SO
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [IN_CH*W-1:0]    in_data,
    input  logic [SI-1:0]         in_sel,
    output logic                  out_valid,
    output logic                  out_err,
    output logic [OUT_CH*W-1:0]   out_data,
    output logic [SOW-1:0]        out_sel
);

    typedef struct packed {
        stg_ctl_t              ctl;
        logic [OUT_CH*W-1:0]   data;
        logic [SOW-1:0]        sel;
    } stg_t;

    logic [IN_CH*W-1:0] tree [LVLS+1];
    stg_t               d;
    stg_t               q;

    always_comb begin
        for (int unsigned j = 0; j <= LVLS; j++) tree[j] = '0;
        tree[0] = in_data;
        for (int unsigned j = 0; j < LVLS; j++) begin
            for (int unsigned c = 0; c < (IN_CH >> (j + 1)); c++) begin
                tree[j+1][c*W +: W] = in_sel[j] ? tree[j][(2*c+1)*W +: W] : tree[j][2*c*W +: W];
            end
        end
        d.ctl.valid = in_valid;
        d.ctl.err   = in_err;
        d.data      = tree[LVLS][OUT_CH*W-1:0];
        // Consumed bits are shifted out; the last stage keeps a dummy zero bit.
        d.sel       = SOW'(in_sel >> LVLS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

    assign out_valid = q.ctl.valid;
    assign out_err   = q.ctl.err;
    assign out_data  = q.data;
    assign out_sel   = q.sel;

endmodule

// File: rtl/pipe_mux_n.sv
// Pipelined N:1 mux with valid/ready flow control and out-of-range select flagging.
// Optional saturating stall counter port enabled by PIPE_MUX_STALL_CNT_EN.
module pipe_mux_n
    import pipe_mux_pkg::*;
#(
    parameter int unsigned N           = 16,
    parameter int unsigned W           = 8,
    parameter int unsigned LVL_PER_STG = 2,
    localparam int unsigned SW         = calc_sw(N)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  data_in,
    input  logic [SW-1:0]   sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    data_out,
    output logic            sel_err
`ifdef PIPE_MUX_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    localparam int unsigned D  = calc_d(N);
    localparam int unsigned L  = calc_l(N, LVL_PER_STG);
    localparam int unsigned NP = 1 << D;

    logic            stall;
    logic            en;
    logic            sel_oor;
    logic [NP*W-1:0] data_pad;

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = en;

    // Padded channels are zero, so an out-of-range select already yields zero data.
    assign data_pad = (NP*W)'(data_in);
    assign sel_oor  = ({1'b0, sel} >= (SW+1)'(N));

    for (genvar s = 0; s < L; s++) begin : g_stg
        localparam int unsigned SI  = stg_sel_in(N, LVL_PER_STG, s);
        localparam int unsigned LV  = stg_lvls(N, LVL_PER_STG, s);
        localparam int unsigned SO  = SI - LV;
        localparam int unsigned SOW = (SO > 0) ? SO : 1;

        logic                    vi;
        logic                    ei;
        logic [(1 << SI)*W-1:0]  di;
        logic [SI-1:0]           si;
        logic                    v;
        logic                    e;
        logic [(1 << SO)*W-1:0]  dat;
        logic [SOW-1:0]          sl;

        if (s == 0) begin : g_head
            assign vi = in_valid;
            assign ei = sel_oor;
            assign di = data_pad;
            assign si = sel;
        end else begin : g_link
            assign vi = g_stg[s-1].v;
            assign ei = g_stg[s-1].e;
            assign di = g_stg[s-1].dat;
            assign si = g_stg[s-1].sl;
        end

        pipe_mux_stg #(
            .W    (W),
            .SI   (SI),
            .LVLS (LV)
        ) u_stg (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (vi),
            .in_err    (ei),
            .in_data   (di),
            .in_sel    (si),
            .out_valid (v),
            .out_err   (e),
            .out_data  (dat),
            .out_sel   (sl)
        );
    end

    assign out_valid = g_stg[L-1].v;
    assign sel_err   = g_stg[L-1].e;
    assign data_out  = g_stg[L-1].dat;

`ifdef PIPE_MUX_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
